ecc_nibble_io: RTL and testbench



---
 rtl/ecc_nibble_io.sv | 160 ++++++++++++++++
 tb/tb_ecc_nibble_io.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_nibble_io.sv
// Digit-serial pad front end for the ECC kP core. It assembles five operands from DIGIT-wide pins,
// launches the core, then streams the latched (x, y) result back out one digit per cycle.
module ecc_nibble_io #(
  parameter int SIZE      = 32,
  parameter int DIGIT     = 4,
  parameter int MSB_FIRST = 0,
  parameter int TIMEOUT   = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DIGIT-1:0]  a,
  input  logic [DIGIT-1:0]  prime,
  input  logic [DIGIT-1:0]  k,
  input  logic [DIGIT-1:0]  Px,
  input  logic [DIGIT-1:0]  Py,
  output logic              o_core_start,
  output logic [SIZE-1:0]   o_a,
  output logic [SIZE-1:0]   o_prime,
  output logic [SIZE-1:0]   o_k,
  output logic [SIZE-1:0]   o_px,
  output logic [SIZE-1:0]   o_py,
  input  logic              i_core_done,
  input  logic [SIZE-1:0]   i_core_x,
  input  logic [SIZE-1:0]   i_core_y,
  output logic [DIGIT-1:0]  kPx,
  output logic [DIGIT-1:0]  kPy,
  output logic              done,
  output logic              o_busy,
  output logic              o_timeout,
  output logic [2:0]        o_state
);

  localparam int NDIG = SIZE / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int WW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
  localparam logic [WW-1:0] WLIM = WW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, DONE, STREAM} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WW-1:0]   wcnt;
  logic [SIZE-1:0] res_x;
  logic [SIZE-1:0] res_y;

  assign o_state = state;

  // Bit offset of digit i; the same placement serves both the load and the stream direction.
  function automatic int shamt(input logic [CW-1:0] i);
    return (MSB_FIRST != 0) ? (NDIG - 1 - int'(i)) * DIGIT : int'(i) * DIGIT;
  endfunction

  function automatic logic [SIZE-1:0] put(input logic [SIZE-1:0] w, input logic [DIGIT-1:0] d,
                                          input logic [CW-1:0] i);
    logic [SIZE-1:0] m;
    m = SIZE'({DIGIT{1'b1}}) << shamt(i);
    return (w & ~m) | (SIZE'(d) << shamt(i));
  endfunction

  function automatic logic [DIGIT-1:0] get(input logic [SIZE-1:0] w, input logic [CW-1:0] i);
    logic [SIZE-1:0] t;
    t = w >> shamt(i);
    return t[DIGIT-1:0];
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      wcnt         <= '0;
      o_a          <= '0;
      o_prime      <= '0;
      o_k          <= '0;
      o_px         <= '0;
      o_py         <= '0;
      res_x        <= '0;
      res_y        <= '0;
      kPx          <= '0;
      kPy          <= '0;
      o_core_start <= 1'b0;
      done         <= 1'b0;
      o_busy       <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_core_start <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            o_a       <= put(o_a, a, '0);
            o_prime   <= put(o_prime, prime, '0);
            o_k       <= put(o_k, k, '0);
            o_px      <= put(o_px, Px, '0);
            o_py      <= put(o_py, Py, '0);
            cnt       <= CW'(1);
            o_timeout <= 1'b0;
            o_busy    <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          o_a     <= put(o_a, a, cnt);
          o_prime <= put(o_prime, prime, cnt);
          o_k     <= put(o_k, k, cnt);
          o_px    <= put(o_px, Px, cnt);
          o_py    <= put(o_py, Py, cnt);
          if (cnt == LAST) begin
            cnt          <= '0;
            wcnt         <= '0;
            o_core_start <= 1'b1;
            state        <= WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          // A done arriving on the final watchdog cycle still wins over the abort.
          if (i_core_done) begin
            res_x <= i_core_x;
            res_y <= i_core_y;
            done  <= 1'b1;
            state <= DONE;
          end else if (TIMEOUT > 0) begin
            if (wcnt + 1'b1 == WLIM) begin
              wcnt      <= '0;
              o_timeout <= 1'b1;
              o_busy    <= 1'b0;
              state     <= IDLE;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        DONE: begin
          cnt   <= '0;
          kPx   <= get(res_x, '0);
          kPy   <= get(res_y, '0);
          state <= STREAM;
        end
        STREAM: begin
          if (cnt == LAST) begin
            cnt    <= '0;
            kPx    <= '0;
            kPy    <= '0;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            kPx <= get(res_x, cnt + 1'b1);
            kPy <= get(res_y, cnt + 1'b1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_nibble_io.sv
// Directed bench for ecc_nibble_io: LSB/MSB-first 32/4 instances, a watchdog instance and a 16/2 width variant.
module tb_ecc_nibble_io;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  a_d = '0, p_d = '0, k_d = '0, px_d = '0, py_d = '0;
  logic        core_done = 1'b0;
  logic [31:0] core_x = '0, core_y = '0;

  logic        cs0, done0, busy0, to0;
  logic [31:0] oa0, op0, ok0, opx0, opy0;
  logic [3:0]  kx0, ky0;
  logic [2:0]  st0;

  logic        cs1, done1, busy1, to1;
  logic [31:0] oa1, op1, ok1, opx1, opy1;
  logic [3:0]  kx1, ky1;
  logic [2:0]  st1;

  logic        s2_start = 1'b0, s2_done = 1'b0;
  logic [1:0]  s2_a = '0;
  logic [15:0] s2_x = '0, s2_y = '0;
  logic        cs2, done2, busy2, to2;
  logic [15:0] oa2, op2, ok2, opx2, opy2;
  logic [1:0]  kx2, ky2;
  logic [2:0]  st2;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  logic [3:0] f1[8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
  logic [3:0] f3[8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1, 4'h2};
  logic [3:0] lx[8] = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
  logic [3:0] ly[8] = '{4'hE, 4'hF, 4'hA, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] mx[8] = '{4'hD, 4'hE, 4'hA, 4'hD, 4'hB, 4'hE, 4'hE, 4'hF};
  logic [3:0] my[8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hC, 4'hA, 4'hF, 4'hE};
  logic [1:0] wx[8] = '{2'd3, 2'd1, 2'd0, 2'd3, 2'd1, 2'd0, 2'd3, 2'd2};

  ecc_nibble_io #(.SIZE(32), .DIGIT(4), .MSB_FIRST(0), .TIMEOUT(16)) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .a(a_d), .prime(p_d), .k(k_d), .Px(px_d), .Py(py_d),
    .o_core_start(cs0), .o_a(oa0), .o_prime(op0), .o_k(ok0), .o_px(opx0), .o_py(opy0),
    .i_core_done(core_done), .i_core_x(core_x), .i_core_y(core_y),
    .kPx(kx0), .kPy(ky0), .done(done0), .o_busy(busy0), .o_timeout(to0), .o_state(st0));

  ecc_nibble_io #(.SIZE(32), .DIGIT(4), .MSB_FIRST(1), .TIMEOUT(0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .a(a_d), .prime(p_d), .k(k_d), .Px(px_d), .Py(py_d),
    .o_core_start(cs1), .o_a(oa1), .o_prime(op1), .o_k(ok1), .o_px(opx1), .o_py(opy1),
    .i_core_done(core_done), .i_core_x(core_x), .i_core_y(core_y),
    .kPx(kx1), .kPy(ky1), .done(done1), .o_busy(busy1), .o_timeout(to1), .o_state(st1));

  ecc_nibble_io #(.SIZE(16), .DIGIT(2), .MSB_FIRST(0), .TIMEOUT(0)) u2 (
    .i_clk(clk), .i_rst(rst), .i_start(s2_start),
    .a(s2_a), .prime(s2_a), .k(s2_a), .Px(s2_a), .Py(s2_a),
    .o_core_start(cs2), .o_a(oa2), .o_prime(op2), .o_k(ok2), .o_px(opx2), .o_py(opy2),
    .i_core_done(s2_done), .i_core_x(s2_x), .i_core_y(s2_y),
    .kPx(kx2), .kPy(ky2), .done(done2), .o_busy(busy2), .o_timeout(to2), .o_state(st2));

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: one 8-digit frame on the shared 4-bit pins; i_start is re-pulsed at digit ign_at
  task automatic load_frame(input logic [3:0] d[8], input int ign_at);
    for (int i = 0; i < 8; i++) begin
      start = (i == 0) || (i == ign_at);
      a_d   = d[i];
      p_d   = d[i];
      k_d   = 4'(i);
      px_d  = 4'hF;
      py_d  = 4'(i);
      step();
      if (i < 7) check("core_start_early", {31'b0, cs0}, 32'd0);
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", {31'b0, busy0}, 32'd0);
    check("rst_oa", oa0, 32'd0);
    check("rst_done", {31'b0, done0}, 32'd0);
    check("rst_kpx", {28'b0, kx0}, 32'd0);
    check("rst_state", {29'b0, st0}, 32'd0);

    // basic load, LSB-first and MSB-first assembly
    load_frame(f1, -1);
    check("core_start", {31'b0, cs0}, 32'd1);
    check("core_start_msb", {31'b0, cs1}, 32'd1);
    check("oa_lsb", oa0, 32'h87654321);
    check("ok_lsb", ok0, 32'h76543210);
    check("opx_lsb", opx0, 32'hFFFFFFFF);
    check("oa_msb", oa1, 32'h12345678);
    check("ok_msb", ok1, 32'h01234567);
    step();
    check("core_start_pulse", {31'b0, cs0}, 32'd0);
    check("oa_stable", oa0, 32'h87654321);

    core_done = 1'b1;
    core_x = 32'hDEADBEEF;
    core_y = 32'h0000CAFE;
    step();
    check("done_pulse", {31'b0, done0}, 32'd1);
    check("done_pulse_msb", {31'b0, done1}, 32'd1);
    check("kpx_before_stream", {28'b0, kx0}, 32'd0);
    core_done = 1'b0;
    core_x = '0;
    core_y = '0;
    for (int i = 0; i < 8; i++) exp_q.push_back({lx[i], ly[i], mx[i], my[i]});
    step();
    check("done_one_cycle", {31'b0, done0}, 32'd0);
    // stream; i_start and i_core_done pulsed mid-stream must be ignored
    for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      check("kpx_lsb", {28'b0, kx0}, {28'b0, e[15:12]});
      check("kpy_lsb", {28'b0, ky0}, {28'b0, e[11:8]});
      check("kpx_msb", {28'b0, kx1}, {28'b0, e[7:4]});
      check("kpy_msb", {28'b0, ky1}, {28'b0, e[3:0]});
      start = (i == 3);
      core_done = (i == 4);
      core_x = (i == 4) ? 32'h11111111 : 32'h0;
      step();
    end
    start = 1'b0;
    core_done = 1'b0;
    core_x = '0;
    check("idle_kpx", {28'b0, kx0}, 32'd0);
    check("idle_kpy", {28'b0, ky0}, 32'd0);
    check("idle_busy", {31'b0, busy0}, 32'd0);
    check("idle_state", {29'b0, st0}, 32'd0);

    // i_core_done in IDLE is ignored
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("idle_done_ignored", {31'b0, done0}, 32'd0);
    check("idle_done_busy", {31'b0, busy0}, 32'd0);
    step();
    check("idle_done_ignored2", {31'b0, done0}, 32'd0);

    // watchdog: no core done; i_start re-pulsed during LOAD
    load_frame(f1, 3);
    check("wd_core_start", {31'b0, cs0}, 32'd1);
    repeat (15) step();
    check("wd_busy_last_wait", {31'b0, busy0}, 32'd1);
    check("wd_timeout_early", {31'b0, to0}, 32'd0);
    step();
    check("wd_timeout", {31'b0, to0}, 32'd1);
    check("wd_busy_drop", {31'b0, busy0}, 32'd0);
    check("wd_no_done", {31'b0, done0}, 32'd0);
    check("wd_disabled_busy", {31'b0, busy1}, 32'd1);
    repeat (3) step();
    check("wd_sticky", {31'b0, to0}, 32'd1);
    check("wd_no_stream", {28'b0, kx0}, 32'd0);

    // new frame clears the timeout, then reset lands in LOAD cycle 4
    for (int i = 0; i < 4; i++) begin
      start = (i == 0);
      a_d = f1[i];
      p_d = f1[i];
      k_d = 4'(i);
      step();
      if (i == 0) begin
        check("timeout_cleared", {31'b0, to0}, 32'd0);
        check("reload_busy", {31'b0, busy0}, 32'd1);
      end
    end
    a_d = f1[4];
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_oa", oa0, 32'd0);
    check("midrst_ok", ok0, 32'd0);
    check("midrst_busy", {31'b0, busy0}, 32'd0);
    check("midrst_state", {29'b0, st0}, 32'd0);
    check("midrst_core_start", {31'b0, cs0}, 32'd0);
    step();

    // fresh frame; core done lands on the 16th WAIT cycle and beats the watchdog
    load_frame(f3, -1);
    check("f3_core_start", {31'b0, cs0}, 32'd1);
    check("f3_oa", oa0, 32'h21FEDCBA);
    repeat (15) step();
    core_done = 1'b1;
    core_x = 32'h12345678;
    core_y = 32'h0;
    step();
    core_done = 1'b0;
    check("race_done", {31'b0, done0}, 32'd1);
    check("race_no_timeout", {31'b0, to0}, 32'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      check("race_kpx", {28'b0, kx0}, 32'(8 - i));
      step();
    end
    check("race_idle_busy", {31'b0, busy0}, 32'd0);

    // width variant: SIZE=16, DIGIT=2
    for (int i = 0; i < 8; i++) begin
      s2_start = (i == 0);
      s2_a = 2'(i % 4);
      step();
      if (i < 7) check("w16_core_start_early", {31'b0, cs2}, 32'd0);
    end
    s2_start = 1'b0;
    check("w16_core_start", {31'b0, cs2}, 32'd1);
    check("w16_oa", {16'b0, oa2}, 32'h0000E4E4);
    s2_done = 1'b1;
    s2_x = 16'hB1C7;
    s2_y = 16'h0003;
    step();
    s2_done = 1'b0;
    check("w16_done", {31'b0, done2}, 32'd1);
    step();
    for (int i = 0; i < 8; i++) begin
      check("w16_kpx", {30'b0, kx2}, {30'b0, wx[i]});
      check("w16_kpy", {30'b0, ky2}, (i == 0) ? 32'd3 : 32'd0);
      step();
    end
    check("w16_idle_kpx", {30'b0, kx2}, 32'd0);
    check("w16_idle_busy", {31'b0, busy2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
